// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and constants for the PC commit-trace capture path
package trace_pkg;

  localparam int TRACE_REC_W = 64;
  localparam int TRACE_BYTES = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous FIFO holding trace records between the change detector and serializer
module trace_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en;
  logic             rd_en;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A write into a full FIFO is legal when the head leaves on the same edge.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_en && !rd_en) begin
      count_d = count_q + 1'b1;
    end else if (!wr_en && rd_en) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_trace_capture.sv
// rtl/pc_trace_capture.sv - records {pc, inst} on every PC change and drains records as a big-endian byte stream
module pc_trace_capture
  import trace_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [31:0]              pc,
  input  logic [31:0]              inst,
  input  logic                     clr_ovf,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);

  localparam logic [2:0] LAST_BYTE = 3'(TRACE_BYTES - 1);

  logic [31:0]            last_pc_q, last_pc_d;
  logic                   overflow_q, overflow_d;
  logic [15:0]            drop_cnt_q, drop_cnt_d;
  ser_state_e             state_q, state_d;
  logic [2:0]             byte_idx_q, byte_idx_d;
  logic [TRACE_REC_W-1:0] shift_q, shift_d;

  trace_rec_t             rec;
  logic [TRACE_REC_W-1:0] fifo_rd_data;
  logic                   push_req;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   drop;

  assign rec.pc   = pc;
  assign rec.inst = inst;

  assign push_req  = en && (pc != last_pc_q);
  assign fifo_push = push_req && (!fifo_full || fifo_pop);
  assign drop      = push_req && fifo_full && !fifo_pop;

  trace_fifo #(
    .WIDTH (TRACE_REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (fifo_push),
    .push_data (rec),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  always_comb begin
    last_pc_d  = last_pc_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (en) last_pc_d = pc;
    // Clearing wins over a drop landing on the same edge.
    if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_d    = fifo_rd_data;
          byte_idx_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (byte_idx_q != LAST_BYTE) begin
            shift_d    = {shift_q[TRACE_REC_W-9:0], 8'h00};
            byte_idx_d = byte_idx_q + 3'd1;
          end else if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_d    = fifo_rd_data;
            byte_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_pc_q  <= PC_RESET;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      state_q    <= IDLE;
      byte_idx_q <= '0;
      shift_q    <= '0;
    end else begin
      last_pc_q  <= last_pc_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
    end
  end

  // Outputs decode the state register directly so reset silences the stream at once.
  assign out_valid = (state_q == SEND);
  assign out_data  = out_valid ? shift_q[TRACE_REC_W-1 -: 8] : 8'h00;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_pc_trace_capture.sv
// tb/tb_pc_trace_capture.sv - scoreboard bench for pc_trace_capture
module tb_pc_trace_capture;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [31:0]   pc;
  logic [31:0]   inst;
  logic          clr_ovf;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic       stalled = 1'b0;
  logic [7:0] held;

  always #5 clk = ~clk;

  pc_trace_capture #(
    .DEPTH    (DEPTH),
    .PC_RESET (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .pc        (pc),
    .inst      (inst),
    .clr_ovf   (clr_ovf),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rec(input logic [31:0] p, input logic [31:0] i);
    logic [63:0] r;
    r = {p, i};
    for (int k = 0; k < 8; k++) exp_q.push_back(r[63 - 8*k -: 8]);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < max_cyc) begin
      tick();
      n++;
    end
    check("drain_in_time", 32'(n < max_cyc), 32'd1);
  endtask

  // Monitor: every accepted byte is matched against the scoreboard; stalled bytes must hold.
  always @(negedge clk) begin
    if (!reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid_held", 32'(out_valid), 32'd1);
        check("stall_data_held", 32'(out_data), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got %h expected none", out_data);
        end else begin
          check("stream_byte", 32'(out_data), 32'(exp_q.pop_front()));
        end
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1;
        held    = out_data;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    reset     = 1'b0;
    en        = 1'b1;
    pc        = 32'h0000_0004;
    inst      = 32'hAAAA_0004;
    clr_ovf   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    expect_rec(32'h0000_0004, 32'hAAAA_0004);
    reset = 1'b1;
    tick();
    check("count_after_release", 32'(count), 32'd1);
    wait_drain(40);

    // Single record, first byte two edges after sampling
    pc   = 32'h0040_0004;
    inst = 32'h2408_0005;
    expect_rec(pc, inst);
    tick();
    check("single_count", 32'(count), 32'd1);
    check("single_valid_early", 32'(out_valid), 32'd0);
    tick();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_first_byte", 32'(out_data), 32'h00);
    wait_drain(40);
    check("single_idle_valid", 32'(out_valid), 32'd0);

    // Backpressure with a constant pc
    pc   = 32'h0040_0008;
    inst = 32'h8C09_0010;
    expect_rec(pc, inst);
    tick();
    for (int c = 0; c < 30; c++) begin
      out_ready = ~out_ready;
      tick();
    end
    out_ready = 1'b1;
    wait_drain(40);
    check("bp_count", 32'(count), 32'd0);

    // Disabled capture hides changes; re-enable against the held last_pc
    en = 1'b0;
    pc = 32'h0000_1234;
    repeat (3) tick();
    pc = 32'h0040_0008;
    en = 1'b1;
    repeat (3) tick();
    check("en_count", 32'(count), 32'd0);
    check("en_valid", 32'(out_valid), 32'd0);

    // Overflow: one record in the shifter, DEPTH in the FIFO, three dropped
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH + 4; k++) begin
      pc   = 32'h0000_1000 + 32'(4 * k);
      inst = 32'hC0DE_0000 + 32'(k);
      if (k <= DEPTH) expect_rec(pc, inst);
      tick();
    end
    check("ovf_count", 32'(count), 32'(DEPTH));
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd3);
    check("ovf_first_byte", 32'(out_data), 32'h00);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("clr_flag", 32'(overflow), 32'd0);
    check("clr_drop_cnt", 32'(drop_cnt), 32'd0);

    // Full FIFO, new pc on the same edge as the last-byte handshake
    out_ready = 1'b1;
    repeat (7) tick();
    check("full_pre_count", 32'(count), 32'(DEPTH));
    pc   = 32'h0000_2000;
    inst = 32'hFEED_0001;
    expect_rec(pc, inst);
    tick();
    check("full_pop_count", 32'(count), 32'(DEPTH));
    check("full_pop_drop_cnt", 32'(drop_cnt), 32'd0);
    check("full_pop_overflow", 32'(overflow), 32'd0);
    wait_drain(200);

    // Async reset after four bytes of a record
    pc   = 32'h0000_3000;
    inst = 32'h1234_5678;
    expect_rec(pc, inst);
    tick();
    tick();
    repeat (4) tick();
    check("mid_remaining", 32'(exp_q.size()), 32'd4);
    #1;
    reset = 1'b0;
    pc    = 32'h0000_0000;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_data", 32'(out_data), 32'd0);
    check("async_count", 32'(count), 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    repeat (10) tick();
    check("post_rst_quiet", 32'(out_valid), 32'd0);
    pc   = 32'h0000_3004;
    inst = 32'h0000_0001;
    expect_rec(pc, inst);
    tick();
    wait_drain(40);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_trace_capture.md
# pc_trace_capture

Commit-trace capture stage sitting directly downstream of the single-cycle CPU top (`sccomp_dataflow`). Samples the CPU's `pc`/`inst` outputs every clock and records a new {pc, inst} entry whenever `pc` differs from the last sampled value. Entries are buffered in a FIFO and drained as a big-endian byte stream over a valid/ready handshake. This gives silicon and FPGA runs the same PC-change trace the simulation flow produces.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `PC_RESET`, 32'h0000_0000: reset value of the last-PC register.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserting it (0) clears all state immediately.
- `en`  in  1  capture enable; while 0, no sampling and `last_pc` is held.
- `pc`  in  32  CPU program counter.
- `inst`  in  32  CPU instruction at `pc`.
- `clr_ovf`  in  1  synchronous clear of `overflow` and `drop_cnt`.
- `out_data`  out  8  current trace byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the byte.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky: at least one record was dropped.
- `drop_cnt`  out  16  number of dropped records; saturates at 16'hFFFF.

## Operation
- **Capture.** On each edge with `en`=1:
  - `last_pc` <= `pc`.
  - If `pc` != `last_pc`, a push of record {pc, inst} (64 bits) is requested.
- **Push acceptance.** A push is accepted if the FIFO is not full, or if a pop happens on the same edge.
- **Dropped push.** Otherwise the record is discarded, `overflow` <= 1, and `drop_cnt` increments (saturating).
- **Clear.** `clr_ovf` has priority over a drop on the same edge: both counters clear and the new drop is not counted.
- **Serializer FSM**, states IDLE and SEND, with a 3-bit `byte_idx` and a 64-bit shift register:
  - IDLE: if the FIFO is non-empty, pop into the shift register, set `byte_idx`=0, go to SEND.
  - SEND: `out_valid`=1 and `out_data`=shift[63:56].
  - On `out_valid`&&`out_ready` with `byte_idx`<7: shift left 8 and increment `byte_idx`.
  - On `out_valid`&&`out_ready` with `byte_idx`==7: if the FIFO is non-empty, pop the next record and stay in SEND with `byte_idx`=0 (back-to-back). Otherwise go to IDLE.
- **Byte order.** pc[31:24], pc[23:16], pc[15:8], pc[7:0], inst[31:24] … inst[7:0].
- **Handshake rules.**
  - `out_data` is stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` never drops without a handshake.
- **Counting.** `count` counts FIFO entries only; the record currently in the shift register is excluded.
- **Reset values.**
  - `out_valid`=0, `out_data`=0, `count`=0, `overflow`=0, `drop_cnt`=0.
  - FSM=IDLE, `last_pc`=PC_RESET.
- **Reset mid-operation.** A partially sent record is abandoned; no byte is emitted after reset asserts.

## Timing
- PC-change sampled at edge N: the entry is visible in `count` after edge N.
- IDLE pops at edge N+1, and `out_valid` is high after edge N+1. Capture to first byte is 2 edges.
- Sustained drain is one byte per cycle with `out_ready`=1. One record takes 8 cycles, with no bubble between records.
- Full FIFO with a pop on the same edge: the push is accepted and `count` is unchanged.
- Empty FIFO with push and IDLE pop on the same edge: the pop sees the pre-edge state, so the pop waits one cycle (no bypass).
- `pc` equal to `PC_RESET` on the first enabled cycle is not captured.
- While `en`=0, `pc` changes are invisible. The first enabled cycle compares against the held `last_pc`.

## Structure
- **Package `trace_pkg`:**
  - `TRACE_REC_W`=64, `TRACE_BYTES`=8.
  - Serializer state enum {IDLE, SEND}.
  - Record struct {pc[31:0], inst[31:0]}.
- **Sub-module `trace_fifo`:** synchronous FIFO with WIDTH and DEPTH parameters.
  - Ports: push/pop, full/empty, count, same async active-low reset.
  - Pointers are $clog2(DEPTH) bits wide and wrap naturally.
- **Top:** instantiates `trace_fifo` and adds the change detector, the drop counters and the serializer FSM.

## Test plan
- **Reset:** hold `reset`=0, drive `pc`=32'h4 → all outputs at reset values. Release reset with `en`=1 → `count`=1 one edge later.
- **Single record:** `pc`=32'h0040_0004, `inst`=32'h2408_0005 for one cycle, `out_ready`=1 → bytes 00,40,00,04,24,08,00,05 starting 2 edges after sampling, then `out_valid`=0.
- **Backpressure:** `out_ready` toggled 1/0 every cycle during a record → each byte is held stable while stalled and the byte sequence is unchanged. `pc` held constant for 10 cycles → no extra record.
- **Overflow:** `out_ready`=0, DEPTH+1+3 distinct PCs. The first record goes to the shift register and DEPTH fill the FIFO → `count`=DEPTH, `overflow`=1, `drop_cnt`=3. Pulse `clr_ovf` → both return to 0.
- **Full with simultaneous pop:** FIFO full and the final byte handshaking on the same edge as a new PC → record accepted, `count` stays DEPTH, `drop_cnt` unchanged.
- **Async reset mid-record:** assert `reset` after byte 3 → `out_valid`=0 immediately, and no further bytes until new PC changes after release.
